ds_hazard_fwd_unit: RTL and testbench

//  Parametrised operand-forwarding and hazard unit for the decode stage; next generation of the

---
 rtl/ds_hazard_fwd_unit_pkg.sv | 26 ++
 rtl/ds_hazard_fwd_unit_if.sv | 49 ++++
 rtl/ds_hazard_fwd_unit_fwd_sel.sv | 65 ++++++
 rtl/ds_hazard_fwd_unit.sv | 117 +++++++++++
 tb/tb_ds_hazard_fwd_unit.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ds_hazard_fwd_unit_pkg.sv
// Shared defaults and hazard-vector layout for the decode-stage forwarding/hazard unit.
// Hazard vector layout: {struct_full, waw, raw[NUM_RD-1:0]}.
package ds_hazard_fwd_unit_pkg;

    localparam int DEF_NUM_FWD  = 3;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_DW       = 32;
    localparam int DEF_AW       = 5;
    localparam int DEF_LU_DEPTH = 4;
    localparam int DEF_CW       = 32;

    localparam int HZ_VEC_WD = DEF_NUM_RD + 2;

    function automatic int hz_vec_wd(input int num_rd);
        return num_rd + 2;
    endfunction

    function automatic int hz_waw_bit(input int num_rd);
        return num_rd;
    endfunction

    function automatic int hz_struct_bit(input int num_rd);
        return num_rd + 1;
    endfunction

endpackage

// File: rtl/ds_hazard_fwd_unit_if.sv
// Decode-stage <-> hazard unit bundle: operand requests, in-flight results, long-unit
// writeback and the resolved operands / hazard status.
interface ds_hazard_fwd_unit_if
    import ds_hazard_fwd_unit_pkg::*;
#(
    parameter int NUM_FWD  = DEF_NUM_FWD,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int LU_DEPTH = DEF_LU_DEPTH,
    parameter int CW       = DEF_CW
) ();

    localparam int SBW = $clog2(LU_DEPTH + 1);

    logic                      ds_valid;
    logic                      ds_fire;
    logic [NUM_RD-1:0]         src_en;
    logic [NUM_RD*AW-1:0]      src_addr;
    logic [NUM_RD*DW-1:0]      rf_rdata;
    logic                      ds_we;
    logic [AW-1:0]             ds_dest;
    logic                      ds_long;
    logic [NUM_FWD-1:0]        fwd_valid;
    logic [NUM_FWD-1:0]        fwd_ready;
    logic [NUM_FWD*AW-1:0]     fwd_dest;
    logic [NUM_FWD*DW-1:0]     fwd_res;
    logic                      lu_wb_valid;
    logic [AW-1:0]             lu_wb_dest;
    logic [DW-1:0]             lu_wb_data;
    logic [NUM_RD*DW-1:0]      src_value;
    logic                      ds_ready_go;
    logic [hz_vec_wd(NUM_RD)-1:0] hazard_vec;
    logic [SBW-1:0]            sb_busy_cnt;
    logic [CW-1:0]             stall_cnt;

    modport master (
        output ds_valid, ds_fire, src_en, src_addr, rf_rdata, ds_we, ds_dest, ds_long,
               fwd_valid, fwd_ready, fwd_dest, fwd_res, lu_wb_valid, lu_wb_dest, lu_wb_data,
        input  src_value, ds_ready_go, hazard_vec, sb_busy_cnt, stall_cnt
    );

    modport slave (
        input  ds_valid, ds_fire, src_en, src_addr, rf_rdata, ds_we, ds_dest, ds_long,
               fwd_valid, fwd_ready, fwd_dest, fwd_res, lu_wb_valid, lu_wb_dest, lu_wb_data,
        output src_value, ds_ready_go, hazard_vec, sb_busy_cnt, stall_cnt
    );

endinterface

// File: rtl/ds_hazard_fwd_unit_fwd_sel.sv
// Per-read-port operand resolver: youngest-first scan of in-flight results, then long-unit
// writeback bypass, then scoreboard check, else the register file value.
module ds_fwd_sel
    import ds_hazard_fwd_unit_pkg::*;
#(
    parameter int NUM_FWD = DEF_NUM_FWD,
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW
) (
    input  logic                  src_en,
    input  logic [AW-1:0]         src_addr,
    input  logic [DW-1:0]         rf_rdata,
    input  logic                  src_busy,
    input  logic [NUM_FWD-1:0]    fwd_valid,
    input  logic [NUM_FWD-1:0]    fwd_ready,
    input  logic [NUM_FWD*AW-1:0] fwd_dest,
    input  logic [NUM_FWD*DW-1:0] fwd_res,
    input  logic                  lu_wb_valid,
    input  logic [AW-1:0]         lu_wb_dest,
    input  logic [DW-1:0]         lu_wb_data,
    output logic [DW-1:0]         src_value,
    output logic                  raw
);

    logic [NUM_FWD-1:0] match;
    logic               hit;
    logic               hit_ready;
    logic [DW-1:0]      hit_res;

    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_match
            assign match[gi] = fwd_valid[gi] && (fwd_dest[gi*AW +: AW] == src_addr);
        end
    endgenerate

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        hit       = 1'b0;
        hit_ready = 1'b0;
        hit_res   = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit       = 1'b1;
                hit_ready = fwd_ready[k];
                hit_res   = fwd_res[k*DW +: DW];
            end
        end
    end

    always_comb begin
        src_value = rf_rdata;
        raw       = 1'b0;
        if (src_en && (src_addr != '0)) begin
            if (hit) begin
                if (hit_ready) src_value = hit_res;
                else           raw       = 1'b1;
            end else if (lu_wb_valid && (lu_wb_dest == src_addr)) begin
                src_value = lu_wb_data;
            end else if (src_busy) begin
                raw = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ds_hazard_fwd_unit.sv
// Decode-stage forwarding and hazard unit: per-port operand resolution, long-latency
// register scoreboard, WAW/structural checks and a saturating stall counter.
module ds_hazard_fwd_unit
    import ds_hazard_fwd_unit_pkg::*;
#(
    parameter int NUM_FWD  = DEF_NUM_FWD,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int LU_DEPTH = DEF_LU_DEPTH,
    parameter int CW       = DEF_CW
) (
    input  logic                 clk,
    input  logic                 reset,
    ds_hazard_fwd_unit_if.slave  bus
);

    localparam int NREG = 1 << AW;
    localparam int SBW  = $clog2(LU_DEPTH + 1);
    localparam int HZW  = hz_vec_wd(NUM_RD);

    logic [NREG-1:0]      busy_reg, busy_next;
    logic [SBW-1:0]       cnt_reg, cnt_next;
    logic [CW-1:0]        stall_reg, stall_next;
    logic [NUM_RD-1:0]    raw;
    logic [NUM_RD*DW-1:0] src_value_w;
    logic [HZW-1:0]       hazard_w;
    logic                 ready_go;
    logic                 waw;
    logic                 struct_full;
    logic                 sb_set;
    logic                 sb_clr;
    logic                 lu_hits_dest;

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
            ds_fwd_sel #(
                .NUM_FWD (NUM_FWD),
                .DW      (DW),
                .AW      (AW)
            ) u_sel (
                .src_en      (bus.src_en[gi]),
                .src_addr    (bus.src_addr[gi*AW +: AW]),
                .rf_rdata    (bus.rf_rdata[gi*DW +: DW]),
                .src_busy    (busy_reg[bus.src_addr[gi*AW +: AW]]),
                .fwd_valid   (bus.fwd_valid),
                .fwd_ready   (bus.fwd_ready),
                .fwd_dest    (bus.fwd_dest),
                .fwd_res     (bus.fwd_res),
                .lu_wb_valid (bus.lu_wb_valid),
                .lu_wb_dest  (bus.lu_wb_dest),
                .lu_wb_data  (bus.lu_wb_data),
                .src_value   (src_value_w[gi*DW +: DW]),
                .raw         (raw[gi])
            );
        end
    endgenerate

    // A writeback landing this cycle on the destination retires the older write in time.
    assign lu_hits_dest = bus.lu_wb_valid && (bus.lu_wb_dest == bus.ds_dest);
    assign waw          = bus.ds_we && (bus.ds_dest != '0) && busy_reg[bus.ds_dest] && !lu_hits_dest;
    assign struct_full  = bus.ds_long && (cnt_reg == SBW'(LU_DEPTH)) && !bus.lu_wb_valid;

    always_comb begin
        hazard_w                          = '0;
        hazard_w[NUM_RD-1:0]              = raw;
        hazard_w[hz_waw_bit(NUM_RD)]      = waw;
        hazard_w[hz_struct_bit(NUM_RD)]   = struct_full;
    end

    assign ready_go        = ~|hazard_w;
    assign bus.hazard_vec  = hazard_w;
    assign bus.ds_ready_go = ready_go;
    assign bus.src_value   = src_value_w;
    assign bus.sb_busy_cnt = cnt_reg;
    assign bus.stall_cnt   = stall_reg;

    // Writebacks to an idle register are dropped so the count stays consistent with busy[].
    assign sb_set = bus.ds_fire && bus.ds_we && bus.ds_long && (bus.ds_dest != '0);
    assign sb_clr = bus.lu_wb_valid && busy_reg[bus.lu_wb_dest];

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            assign busy_next[gi] = (sb_set && (bus.ds_dest == AW'(gi))) ||
                                   (busy_reg[gi] && !(sb_clr && (bus.lu_wb_dest == AW'(gi))));
        end
    endgenerate

    always_comb begin
        cnt_next = cnt_reg;
        case ({sb_set, sb_clr})
            2'b10:   cnt_next = cnt_reg + SBW'(1);
            2'b01:   cnt_next = cnt_reg - SBW'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    always_comb begin
        stall_next = stall_reg;
        if (bus.ds_valid && !ready_go && (stall_reg != '1)) begin
            stall_next = stall_reg + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg  <= '0;
            cnt_reg   <= '0;
            stall_reg <= '0;
        end else begin
            busy_reg  <= busy_next;
            cnt_reg   <= cnt_next;
            stall_reg <= stall_next;
        end
    end

endmodule

// File: tb/tb_ds_hazard_fwd_unit.sv
// Bench for ds_hazard_fwd_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based scoreboard model.
module tb_ds_hazard_fwd_unit;

    localparam int NUM_FWD  = 3;
    localparam int NUM_RD   = 2;
    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int LU_DEPTH = 4;
    localparam int CW       = 4;
    localparam int HZW      = NUM_RD + 2;
    localparam int STALL_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    ds_hazard_fwd_unit_if #(
        .NUM_FWD(NUM_FWD), .NUM_RD(NUM_RD), .DW(DW), .AW(AW), .LU_DEPTH(LU_DEPTH), .CW(CW)
    ) bus ();

    ds_hazard_fwd_unit #(
        .NUM_FWD(NUM_FWD), .NUM_RD(NUM_RD), .DW(DW), .AW(AW), .LU_DEPTH(LU_DEPTH), .CW(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    int outq[$];          // destinations of outstanding long-latency writes
    int stall_m = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_busy(input int a);
        foreach (outq[j]) if (outq[j] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_eval(output logic [HZW-1:0] hz, output logic [NUM_RD*DW-1:0] val);
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        bit            done;
        hz  = '0;
        val = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            a    = bus.src_addr[i*AW +: AW];
            v    = bus.rf_rdata[i*DW +: DW];
            done = 1'b0;
            if (bus.src_en[i] && a != '0) begin
                for (int k = 0; k < NUM_FWD; k++) begin
                    if (!done && bus.fwd_valid[k] && bus.fwd_dest[k*AW +: AW] == a) begin
                        done = 1'b1;
                        if (bus.fwd_ready[k]) v = bus.fwd_res[k*DW +: DW];
                        else                  hz[i] = 1'b1;
                    end
                end
                if (!done) begin
                    if (bus.lu_wb_valid && bus.lu_wb_dest == a) v = bus.lu_wb_data;
                    else if (m_busy(int'(a)))                   hz[i] = 1'b1;
                end
            end
            val[i*DW +: DW] = v;
        end
        hz[NUM_RD]     = bus.ds_we && bus.ds_dest != '0 && m_busy(int'(bus.ds_dest)) &&
                         !(bus.lu_wb_valid && bus.lu_wb_dest == bus.ds_dest);
        hz[NUM_RD + 1] = bus.ds_long && outq.size() == LU_DEPTH && !bus.lu_wb_valid;
    endfunction

    task automatic m_update();
        logic [HZW-1:0]       hz;
        logic [NUM_RD*DW-1:0] val;
        bit                   found;
        if (reset) begin
            outq.delete();
            stall_m = 0;
            return;
        end
        m_eval(hz, val);
        if (bus.ds_valid && hz != '0 && stall_m < STALL_MAX) stall_m++;
        if (bus.lu_wb_valid) begin
            found = 1'b0;
            for (int j = 0; j < outq.size(); j++) begin
                if (!found && outq[j] == int'(bus.lu_wb_dest)) begin
                    outq.delete(j);
                    found = 1'b1;
                end
            end
            assert (found) else $error("long-unit writeback to an idle register");
        end
        if (bus.ds_fire && bus.ds_we && bus.ds_long && bus.ds_dest != '0)
            outq.push_back(int'(bus.ds_dest));
    endtask

    // Compare on the falling edge, advance the model on the rising edge.
    initial begin
        logic [HZW-1:0]       hz;
        logic [NUM_RD*DW-1:0] val;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                m_eval(hz, val);
                chk("hazard_vec", 64'(bus.hazard_vec), 64'(hz));
                chk("ds_ready_go", 64'(bus.ds_ready_go), 64'(hz == '0));
                chk("sb_busy_cnt", 64'(bus.sb_busy_cnt), 64'(outq.size()));
                chk("stall_cnt", 64'(bus.stall_cnt), 64'(stall_m));
                for (int i = 0; i < NUM_RD; i++)
                    if (!hz[i]) chk($sformatf("src_value%0d", i),
                                    64'(bus.src_value[i*DW +: DW]), 64'(val[i*DW +: DW]));
            end
            @(posedge clk);
            m_update();
        end
    end

    task automatic idle();
        bus.ds_valid    = 1'b0;
        bus.ds_fire     = 1'b0;
        bus.src_en      = '0;
        bus.src_addr    = '0;
        bus.rf_rdata    = '0;
        bus.ds_we       = 1'b0;
        bus.ds_dest     = '0;
        bus.ds_long     = 1'b0;
        bus.fwd_valid   = '0;
        bus.fwd_ready   = '0;
        bus.fwd_dest    = '0;
        bus.fwd_res     = '0;
        bus.lu_wb_valid = 1'b0;
        bus.lu_wb_dest  = '0;
        bus.lu_wb_data  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic rand_drive();
        logic [HZW-1:0]       hz;
        logic [NUM_RD*DW-1:0] val;
        bus.ds_valid = ($urandom_range(0, 3) != 0);
        bus.src_en   = NUM_RD'($urandom);
        for (int i = 0; i < NUM_RD; i++) begin
            bus.src_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
            bus.rf_rdata[i*DW +: DW] = $urandom;
        end
        bus.ds_we   = 1'($urandom);
        bus.ds_long = 1'($urandom);
        bus.ds_dest = AW'($urandom_range(0, 7));
        for (int k = 0; k < NUM_FWD; k++) begin
            bus.fwd_valid[k]          = 1'($urandom);
            bus.fwd_ready[k]          = ($urandom_range(0, 3) != 0);
            bus.fwd_dest[k*AW +: AW]  = AW'($urandom_range(0, 7));
            bus.fwd_res[k*DW +: DW]   = $urandom;
        end
        if (outq.size() > 0 && $urandom_range(0, 2) == 0) begin
            bus.lu_wb_valid = 1'b1;
            bus.lu_wb_dest  = AW'(outq[$urandom_range(0, outq.size() - 1)]);
        end else begin
            bus.lu_wb_valid = 1'b0;
            bus.lu_wb_dest  = AW'($urandom_range(0, 7));
        end
        bus.lu_wb_data = $urandom;
        bus.ds_fire    = 1'b0;
        m_eval(hz, val);
        bus.ds_fire = bus.ds_valid && hz == '0 && ($urandom_range(0, 1) == 1);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state
        at_neg();
        chk("rst_sb_busy_cnt", 64'(bus.sb_busy_cnt), 64'd0);
        chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("rst_ready_go", 64'(bus.ds_ready_go), 64'd1);

        // Un-ready load in ES to r5, read r5 on port 0
        tick(); idle();
        bus.ds_valid = 1'b1; bus.src_en = 2'b01; bus.src_addr[0 +: AW] = 5'd5;
        bus.fwd_valid = 3'b001; bus.fwd_ready = 3'b000; bus.fwd_dest[0 +: AW] = 5'd5;
        at_neg();
        chk("load_use_hazard", 64'(bus.hazard_vec), 64'h1);
        chk("load_use_ready_go", 64'(bus.ds_ready_go), 64'd0);
        chk("load_use_stall0", 64'(bus.stall_cnt), 64'd0);
        tick(); at_neg();
        chk("load_use_stall1", 64'(bus.stall_cnt), 64'd1);
        tick(); at_neg();
        chk("load_use_stall2", 64'(bus.stall_cnt), 64'd2);

        // Youngest source wins
        tick(); idle();
        bus.ds_valid = 1'b1; bus.src_en = 2'b01; bus.src_addr[0 +: AW] = 5'd3;
        bus.rf_rdata[0 +: DW] = 32'h99;
        bus.fwd_valid = 3'b011; bus.fwd_ready = 3'b011;
        bus.fwd_dest[0 +: AW] = 5'd3; bus.fwd_dest[AW +: AW] = 5'd3;
        bus.fwd_res[0 +: DW] = 32'h11; bus.fwd_res[DW +: DW] = 32'h22;
        at_neg();
        chk("youngest_wins", 64'(bus.src_value[0 +: DW]), 64'h11);
        chk("youngest_no_hazard", 64'(bus.hazard_vec), 64'h0);

        // r0 is never forwarded
        tick(); idle();
        bus.ds_valid = 1'b1; bus.src_en = 2'b10; bus.src_addr[AW +: AW] = 5'd0;
        bus.rf_rdata[DW +: DW] = 32'h1234;
        bus.fwd_valid = 3'b001; bus.fwd_ready = 3'b001;
        bus.fwd_dest[0 +: AW] = 5'd0; bus.fwd_res[0 +: DW] = 32'hFF;
        at_neg();
        chk("r0_rf_value", 64'(bus.src_value[DW +: DW]), 64'h1234);
        chk("r0_no_hazard", 64'(bus.hazard_vec), 64'h0);

        // Long op to r7, dependent read, writeback bypass
        tick(); idle();
        bus.ds_valid = 1'b1; bus.ds_we = 1'b1; bus.ds_long = 1'b1; bus.ds_dest = 5'd7; bus.ds_fire = 1'b1;
        at_neg();
        chk("div_issue_ready", 64'(bus.ds_ready_go), 64'd1);
        tick(); idle();
        bus.ds_valid = 1'b1; bus.src_en = 2'b01; bus.src_addr[0 +: AW] = 5'd7;
        bus.rf_rdata[0 +: DW] = 32'h5;
        at_neg();
        chk("div_dep_hazard", 64'(bus.hazard_vec), 64'h1);
        chk("div_cnt1", 64'(bus.sb_busy_cnt), 64'd1);
        tick();
        bus.lu_wb_valid = 1'b1; bus.lu_wb_dest = 5'd7; bus.lu_wb_data = 32'hABCD; bus.ds_fire = 1'b1;
        at_neg();
        chk("div_wb_bypass", 64'(bus.src_value[0 +: DW]), 64'hABCD);
        chk("div_wb_ready_go", 64'(bus.ds_ready_go), 64'd1);
        tick(); idle();
        at_neg();
        chk("div_cnt0", 64'(bus.sb_busy_cnt), 64'd0);

        // Fill the scoreboard with r1..r4
        for (int r = 1; r <= 4; r++) begin
            tick(); idle();
            bus.ds_valid = 1'b1; bus.ds_we = 1'b1; bus.ds_long = 1'b1;
            bus.ds_dest = AW'(r); bus.ds_fire = 1'b1;
        end
        tick(); idle();
        bus.ds_valid = 1'b1; bus.ds_we = 1'b1; bus.ds_long = 1'b1; bus.ds_dest = 5'd5;
        at_neg();
        chk("struct_full_hazard", 64'(bus.hazard_vec), 64'h8);
        chk("struct_full_cnt", 64'(bus.sb_busy_cnt), 64'd4);
        tick();
        bus.lu_wb_valid = 1'b1; bus.lu_wb_dest = 5'd1; bus.lu_wb_data = 32'h77; bus.ds_fire = 1'b1;
        at_neg();
        chk("struct_wb_no_hazard", 64'(bus.hazard_vec), 64'h0);
        tick(); idle();
        at_neg();
        chk("struct_wb_cnt_stays", 64'(bus.sb_busy_cnt), 64'd4);

        // Reset drops the scoreboard: r2 was busy
        tick(); reset = 1'b1; idle();
        tick(); reset = 1'b0;
        bus.ds_valid = 1'b1; bus.src_en = 2'b01; bus.src_addr[0 +: AW] = 5'd2;
        at_neg();
        chk("reset_cnt", 64'(bus.sb_busy_cnt), 64'd0);
        chk("reset_stall", 64'(bus.stall_cnt), 64'd0);
        chk("reset_busy_cleared", 64'(bus.hazard_vec), 64'h0);

        // Drive stall_cnt to max-1, then hold the stall
        tick();
        bus.fwd_valid = 3'b001; bus.fwd_ready = 3'b000; bus.fwd_dest[0 +: AW] = 5'd2;
        at_neg();
        for (int c = 0; c < STALL_MAX - 1; c++) tick();
        at_neg();
        chk("stall_max_minus1", 64'(bus.stall_cnt), 64'(STALL_MAX - 1));
        for (int c = 0; c < 3; c++) begin
            tick(); at_neg();
            chk("stall_saturate", 64'(bus.stall_cnt), 64'(STALL_MAX));
        end
        tick(); reset = 1'b1; idle();
        tick(); reset = 1'b0;
        at_neg();
        chk("reset2_stall", 64'(bus.stall_cnt), 64'd0);
        chk("reset2_cnt", 64'(bus.sb_busy_cnt), 64'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            tick();
            rand_drive();
        end
        tick(); idle();
        at_neg();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
